// File: rtl/squash_ctrl_pkg.sv
// Shared types for the branch squash controller: ROB index, BRU writeback record, squash record,
// FSM state encoding and the wrap-aware ROB age comparison.
package squash_ctrl_pkg;

  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned PC_W      = 32;

  typedef struct packed {
    logic                 flag;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t         rob_idx;
    logic            has_mispred;
    logic            branch_taken;
    logic [PC_W-1:0] branch_npc;
  } branchwbInfo_t;

  typedef struct packed {
    logic            dueToBranch;
    logic            branch_taken;
    logic [PC_W-1:0] arch_pc;
  } squashInfo_t;

  // Held mispredict: only the fields needed to build the squash record.
  typedef struct packed {
    robIdx_t         rob_idx;
    logic            branch_taken;
    logic [PC_W-1:0] branch_npc;
  } heldBr_t;

  typedef enum logic [1:0] {IDLE, PEND, SQUASH, RECOVER} squash_state_e;

  // a is older than b; the flag flips on every ROB wrap, which inverts index order.
  function automatic logic robIdx_older(robIdx_t a, robIdx_t b);
    return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/squash_ctrl_brwb_oldest_sel.sv
// Combinational reduction of all BRU writeback ports to the oldest valid mispredict.
// A strictly-older test keeps the lowest port on an age tie.
module brwb_oldest_sel
  import squash_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BRWB = 2
) (
  input  logic          [NUM_BRWB-1:0] i_brwb_vld,
  input  branchwbInfo_t [NUM_BRWB-1:0] i_brwb_info,
  output logic                         o_vld,
  output branchwbInfo_t                o_info
);

  logic          best_vld;
  branchwbInfo_t best_info;

  always_comb begin
    best_vld  = 1'b0;
    best_info = '0;
    for (int i = 0; i < NUM_BRWB; i++) begin
      if (i_brwb_vld[i] && i_brwb_info[i].has_mispred &&
          (!best_vld || robIdx_older(i_brwb_info[i].rob_idx, best_info.rob_idx))) begin
        best_vld  = 1'b1;
        best_info = i_brwb_info[i];
      end
    end
  end

  assign o_vld  = best_vld;
  assign o_info = best_info;

endmodule

// File: rtl/squash_ctrl.sv
// Branch squash sequencer: holds the oldest mispredict, pulses a squash when it retires at the
// ROB head, then stalls the front end. SQUASH_CTRL_PERF_EN adds saturating perf counters.
module squash_ctrl
  import squash_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BRWB       = 2,
  parameter int unsigned RECOVER_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic          [NUM_BRWB-1:0] i_brwb_vld,
  input  branchwbInfo_t [NUM_BRWB-1:0] i_brwb_info,
  input  robIdx_t                      i_rob_head,
  input  logic                         i_head_commit,
  input  logic                         i_except_flush,
  output logic                         o_squash_vld,
  output squashInfo_t                  o_squash_info,
  output robIdx_t                      o_squash_robIdx,
  output logic                         o_stall_front,
  output logic                         o_pending
`ifdef SQUASH_CTRL_PERF_EN
  ,
  output logic          [31:0]         o_perf_squash_cnt,
  output logic          [31:0]         o_perf_pend_cycles
`endif
);

  localparam int unsigned    CntW    = $clog2(RECOVER_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(RECOVER_CYCLES);

  squash_state_e   state_q, state_d;
  heldBr_t         held_q, held_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic          sel_vld;
  branchwbInfo_t sel_info;
  logic          cand_vld;
  heldBr_t       cand;
  logic          head_match;

  brwb_oldest_sel #(
    .NUM_BRWB (NUM_BRWB)
  ) u_sel (
    .i_brwb_vld  (i_brwb_vld),
    .i_brwb_info (i_brwb_info),
    .o_vld       (sel_vld),
    .o_info      (sel_info)
  );

  assign cand_vld   = sel_vld & sel_info.has_mispred;
  assign cand       = '{rob_idx:      sel_info.rob_idx,
                        branch_taken: sel_info.branch_taken,
                        branch_npc:   sel_info.branch_npc};
  assign head_match = i_head_commit && (i_rob_head == held_q.rob_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    if (i_except_flush) begin
      state_d = RECOVER;
      held_d  = '0;
      cnt_d   = CntLoad;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cand_vld) begin
            held_d  = cand;
            state_d = PEND;
          end
        end
        PEND: begin
          // A candidate arriving with the head match is younger than the retiring branch.
          if (head_match) begin
            state_d = SQUASH;
          end else if (cand_vld && robIdx_older(cand.rob_idx, held_q.rob_idx)) begin
            held_d = cand;
          end
        end
        SQUASH: begin
          cnt_d   = CntLoad;
          state_d = RECOVER;
        end
        RECOVER: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q <= CntW'(1)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_squash_vld    = 1'b0;
    o_squash_info   = '0;
    o_squash_robIdx = '0;
    o_stall_front   = 1'b0;
    o_pending       = 1'b0;
    unique case (state_q)
      PEND: o_pending = 1'b1;
      SQUASH: begin
        o_squash_vld    = 1'b1;
        o_squash_info   = '{dueToBranch:  1'b1,
                            branch_taken: held_q.branch_taken,
                            arch_pc:      held_q.branch_npc};
        o_squash_robIdx = held_q.rob_idx;
        o_stall_front   = 1'b1;
      end
      RECOVER: o_stall_front = 1'b1;
      default: ;
    endcase
  end

`ifdef SQUASH_CTRL_PERF_EN
  logic [31:0] perf_squash_q, perf_pend_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_squash_q <= '0;
      perf_pend_q   <= '0;
    end else begin
      if (state_q == SQUASH && perf_squash_q != '1) perf_squash_q <= perf_squash_q + 32'd1;
      if (state_q == PEND && perf_pend_q != '1)     perf_pend_q   <= perf_pend_q + 32'd1;
    end
  end

  assign o_perf_squash_cnt  = perf_squash_q;
  assign o_perf_pend_cycles = perf_pend_q;
`else
  // Default build carries no perf counters.
`endif

endmodule

// File: tb/tb_squash_ctrl.sv
// Self-checking bench for squash_ctrl: directed scenarios plus randomized traffic compared each
// cycle against a counter/age-arithmetic reference model.
module tb_squash_ctrl;
  import squash_ctrl_pkg::*;

  localparam int unsigned NBR = 2;
  localparam int unsigned RC  = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic          [NBR-1:0] brwb_vld;
  branchwbInfo_t [NBR-1:0] brwb_info;
  robIdx_t                 rob_head;
  logic                    head_commit;
  logic                    except_flush;
  logic                    squash_vld;
  squashInfo_t             squash_info;
  robIdx_t                 squash_rob;
  logic                    stall_front;
  logic                    pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_pend, m_pulse;
  int          m_stall;
  logic [5:0]  m_rob;
  bit          m_taken;
  logic [31:0] m_npc;

  squash_ctrl #(
    .NUM_BRWB       (NBR),
    .RECOVER_CYCLES (RC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_brwb_vld      (brwb_vld),
    .i_brwb_info     (brwb_info),
    .i_rob_head      (rob_head),
    .i_head_commit   (head_commit),
    .i_except_flush  (except_flush),
    .o_squash_vld    (squash_vld),
    .o_squash_info   (squash_info),
    .o_squash_robIdx (squash_rob),
    .o_stall_front   (stall_front),
    .o_pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // a older than b: b lies 1..31 entries ahead of a in the 64-value flag+index sequence.
  function automatic bit age_older(logic [5:0] a, logic [5:0] b);
    logic [5:0] d;
    d = b - a;
    return (d != 6'd0) && (d < 6'd32);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_pulse = 0; m_stall = 0; m_rob = '0; m_taken = 0; m_npc = '0;
  endtask

  task automatic model_step();
    bit          cv;
    logic [5:0]  crob;
    bit          ctaken;
    logic [31:0] cnpc;
    cv = 0; crob = '0; ctaken = 0; cnpc = '0;
    for (int p = 0; p < NBR; p++) begin
      if (brwb_vld[p] && brwb_info[p].has_mispred &&
          (!cv || age_older(6'(brwb_info[p].rob_idx), crob))) begin
        cv = 1; crob = 6'(brwb_info[p].rob_idx);
        ctaken = brwb_info[p].branch_taken; cnpc = brwb_info[p].branch_npc;
      end
    end
    if (except_flush) begin
      m_pend = 0; m_pulse = 0; m_stall = RC;
    end else if (m_pulse) begin
      m_pulse = 0; m_stall = RC;
    end else if (m_stall > 0) begin
      m_stall--;
    end else if (m_pend) begin
      if (head_commit && 6'(rob_head) == m_rob) begin
        m_pend = 0; m_pulse = 1;
      end else if (cv && age_older(crob, m_rob)) begin
        m_rob = crob; m_taken = ctaken; m_npc = cnpc;
      end
    end else if (cv) begin
      m_pend = 1; m_rob = crob; m_taken = ctaken; m_npc = cnpc;
    end
  endtask

  task automatic compare_model();
    squashInfo_t ei;
    logic [5:0]  er;
    ei = '0; er = '0;
    if (m_pulse) begin
      ei = '{dueToBranch: 1'b1, branch_taken: m_taken, arch_pc: m_npc};
      er = m_rob;
    end
    check_eq("m_squash_vld", 64'(squash_vld), 64'(m_pulse));
    check_eq("m_squash_info", 64'(squash_info), 64'(ei));
    check_eq("m_squash_rob", 64'(squash_rob), 64'(er));
    check_eq("m_stall_front", 64'(stall_front), 64'(m_pulse || m_stall > 0));
    check_eq("m_pending", 64'(pending), 64'(m_pend));
  endtask

  task automatic clear_in();
    brwb_vld = '0; brwb_info = '0; rob_head = '0; head_commit = 0; except_flush = 0;
  endtask

  task automatic set_port(input int p, input bit fl, input int idx, input logic [31:0] npc,
                          input bit tk);
    brwb_vld[p]                  = 1'b1;
    brwb_info[p].rob_idx.flag    = fl;
    brwb_info[p].rob_idx.idx     = 5'(idx);
    brwb_info[p].has_mispred     = 1'b1;
    brwb_info[p].branch_taken    = tk;
    brwb_info[p].branch_npc      = npc;
  endtask

  task automatic commit_head(input bit fl, input int idx);
    rob_head.flag = fl; rob_head.idx = 5'(idx); head_commit = 1;
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge; inputs cleared.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
    clear_in();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear_in();
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_pending", 64'(pending), 64'd0);
    check_eq("rst_stall", 64'(stall_front), 64'd0);
    check_eq("rst_squash_vld", 64'(squash_vld), 64'd0);
    check_eq("rst_squash_info", 64'(squash_info), 64'd0);
    rst = 1'b1;
    tick();

    // 1: basic mispredict, retire, pulse, stall window
    set_port(0, 0, 5, 32'h8000_0100, 1);
    tick();
    check_eq("t1_pending", 64'(pending), 64'd1);
    commit_head(0, 5);
    tick();
    check_eq("t1_vld", 64'(squash_vld), 64'd1);
    check_eq("t1_info", 64'(squash_info), {30'd0, 1'b1, 1'b1, 32'h8000_0100});
    check_eq("t1_rob", 64'(squash_rob), 64'h05);
    check_eq("t1_stall0", 64'(stall_front), 64'd1);
    check_eq("t1_pending_off", 64'(pending), 64'd0);
    for (int i = 0; i < RC; i++) begin
      tick();
      check_eq("t1_stall_rec", 64'(stall_front), 64'd1);
      check_eq("t1_vld_once", 64'(squash_vld), 64'd0);
    end
    tick();
    check_eq("t1_stall_end", 64'(stall_front), 64'd0);

    // 2: same-cycle selection, replacement by older, drop of younger
    set_port(0, 0, 9, 32'h9, 0);
    set_port(1, 0, 7, 32'h7, 1);
    tick();
    commit_head(0, 9);
    tick();
    check_eq("t2_not9", 64'(squash_vld), 64'd0);
    set_port(0, 0, 3, 32'h3, 0);
    tick();
    set_port(0, 0, 6, 32'h6, 1);
    tick();
    commit_head(0, 7);
    tick();
    check_eq("t2_not7", 64'(squash_vld), 64'd0);
    check_eq("t2_pend", 64'(pending), 64'd1);
    commit_head(0, 3);
    set_port(1, 0, 1, 32'h1, 1); // coincident candidate must be dropped
    tick();
    check_eq("t2_vld", 64'(squash_vld), 64'd1);
    check_eq("t2_rob", 64'(squash_rob), 64'h03);
    check_eq("t2_pc", 64'(squash_info.arch_pc), 64'h3);
    run(RC + 1);

    // 3: wrap-around ordering
    set_port(0, 0, 30, 32'h30, 1);
    tick();
    set_port(1, 1, 2, 32'h102, 0);
    tick();
    commit_head(0, 30);
    tick();
    check_eq("t3a_rob", 64'(squash_rob), 64'h1e);
    run(RC + 1);
    set_port(0, 1, 2, 32'h102, 0);
    tick();
    set_port(0, 0, 30, 32'h30, 1);
    tick();
    commit_head(0, 30);
    tick();
    check_eq("t3b_vld", 64'(squash_vld), 64'd1);
    check_eq("t3b_rob", 64'(squash_rob), 64'h1e);
    run(RC + 1);

    // 4: exception flush while pending
    set_port(0, 0, 4, 32'h44, 0);
    tick();
    check_eq("t4_pend", 64'(pending), 64'd1);
    except_flush = 1;
    tick();
    check_eq("t4_nopulse", 64'(squash_vld), 64'd0);
    check_eq("t4_pend_clr", 64'(pending), 64'd0);
    check_eq("t4_stall", 64'(stall_front), 64'd1);
    run(RC - 1);
    check_eq("t4_stall_last", 64'(stall_front), 64'd1);
    tick();
    check_eq("t4_stall_end", 64'(stall_front), 64'd0);
    commit_head(0, 4);
    tick();
    check_eq("t4_no_late", 64'(squash_vld), 64'd0);

    // 5: writeback during recovery is dropped
    except_flush = 1;
    tick();
    set_port(0, 0, 12, 32'h12, 0);
    tick();
    run(RC);
    check_eq("t5_pend", 64'(pending), 64'd0);
    check_eq("t5_idle", 64'(stall_front), 64'd0);

    // 6: asynchronous reset while pending
    set_port(0, 0, 4, 32'h44, 0);
    tick();
    check_eq("t6_pend", 64'(pending), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_async_pend", 64'(pending), 64'd0);
    check_eq("t6_async_stall", 64'(stall_front), 64'd0);
    check_eq("t6_async_vld", 64'(squash_vld), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    commit_head(0, 4);
    tick();
    check_eq("t6_post_idle", 64'(squash_vld), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NBR; p++) begin
        brwb_vld[p]               = ($urandom_range(0, 3) == 0);
        brwb_info[p].rob_idx      = robIdx_t'(6'($urandom_range(0, 63)));
        brwb_info[p].has_mispred  = ($urandom_range(0, 2) != 0);
        brwb_info[p].branch_taken = 1'($urandom_range(0, 1));
        brwb_info[p].branch_npc   = $urandom;
      end
      head_commit  = ($urandom_range(0, 1) == 1);
      rob_head     = ($urandom_range(0, 2) == 0) ? robIdx_t'(6'($urandom_range(0, 63)))
                                                 : robIdx_t'(m_rob);
      except_flush = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
